// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding and default widths.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int kPC_W  = 10;
  localparam int kLUT_W = 5;
  localparam int kCNT_W = 16;

endpackage

// File: rtl/fetch_unit_if.sv
// Harness-facing bundle of the fetch unit: control inputs, LUT preload port and status outputs.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int PC_W  = kPC_W,
  parameter int LUT_W = kLUT_W,
  parameter int CNT_W = kCNT_W
);
  logic             Start;
  logic             BranchEn;
  logic             Taken;
  logic             Halt;
  logic [LUT_W-1:0] TargetIdx;
  logic             LutWe;
  logic [LUT_W-1:0] LutWaddr;
  logic [PC_W-1:0]  LutWdata;
  logic [PC_W-1:0]  PC;
  logic             Running;
  logic             Done;
  logic             PcWrap;
  logic [CNT_W-1:0] CycleCount;

  modport master (
    output Start, BranchEn, Taken, Halt, TargetIdx, LutWe, LutWaddr, LutWdata,
    input  PC, Running, Done, PcWrap, CycleCount
  );

  modport slave (
    input  Start, BranchEn, Taken, Halt, TargetIdx, LutWe, LutWaddr, LutWdata,
    output PC, Running, Done, PcWrap, CycleCount
  );
endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target table: synchronous write, combinational read, synchronous active-low clear.
module branch_lut #(
  parameter int LUT_W = 5,
  parameter int PC_W  = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [LUT_W-1:0] i_waddr,
  input  logic [PC_W-1:0]  i_wdata,
  input  logic [LUT_W-1:0] i_raddr,
  output logic [PC_W-1:0]  o_rdata
);

  logic [PC_W-1:0] r_mem [2**LUT_W];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**LUT_W; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read sees the pre-edge contents, so a same-edge write never affects a branch.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer: start-run-halt FSM, branch redirect via LUT, cycle counter.
//   state | meaning
//   IDLE  | after reset, waiting for Start; PC held at 0
//   RUN   | instruction at PC executing; PC advances or redirects every edge
//   DONE  | halt executed; PC holds halt address until Start
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W  = kPC_W,
  parameter int LUT_W = kLUT_W,
  parameter int CNT_W = kCNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  fetch_unit_if.slave  bus
);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_running;
  logic             r_done;
  logic             r_pc_wrap;
  logic [CNT_W-1:0] r_cnt;

  logic [PC_W-1:0]  w_lut_rdata;
  logic [PC_W-1:0]  w_pc_inc;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_branch;

  branch_lut #(
    .LUT_W (LUT_W),
    .PC_W  (PC_W)
  ) u_lut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (bus.LutWe),
    .i_waddr (bus.LutWaddr),
    .i_wdata (bus.LutWdata),
    .i_raddr (bus.TargetIdx),
    .o_rdata (w_lut_rdata)
  );

  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_branch  = bus.BranchEn & bus.Taken;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_pc_wrap <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.Start) begin
            r_state   <= RUN;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_pc_wrap <= 1'b0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        RUN: begin
          // Halting cycle still counts as an executed cycle.
          if (r_cnt != '1) r_cnt <= w_cnt_inc;
          if (bus.Halt) begin
            r_state   <= DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_branch) begin
            r_pc <= w_lut_rdata;
          end else begin
            r_pc <= w_pc_inc;
            if (&r_pc) r_pc_wrap <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC         = r_pc;
  assign bus.Running    = r_running;
  assign bus.Done       = r_done;
  assign bus.PcWrap     = r_pc_wrap;
  assign bus.CycleCount = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_unit;
  localparam int PC_W  = 10;
  localparam int LUT_W = 5;
  localparam int CNT_W = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(CNT_W)) bus();

  fetch_unit #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int pc;
    int running;
    int done;
    int wrap;
    int cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model: 0 = idle, 1 = running, 2 = finished.
  int m_mode = 0;
  int m_pc   = 0;
  int m_wrap = 0;
  int m_cnt  = 0;
  int m_lut[1 << LUT_W];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int rn, input int st, input int br, input int tk,
                            input int hl, input int idx, input int we, input int wa,
                            input int wd);
    int target;
    target = m_lut[idx];
    if (rn == 0) begin
      m_mode = 0; m_pc = 0; m_wrap = 0; m_cnt = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
    end else begin
      if (m_mode == 1) begin
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        if (hl != 0) m_mode = 2;
        else if (br != 0 && tk != 0) m_pc = target;
        else begin
          if (m_pc == PC_MOD - 1) m_wrap = 1;
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end else if (st != 0) begin
        m_mode = 1; m_pc = 0; m_cnt = 0; m_wrap = 0;
      end
      if (we != 0) m_lut[wa] = wd;
    end
  endtask

  task automatic cyc(input int rn, input int st, input int br, input int tk, input int hl,
                     input int idx, input int we, input int wa, input int wd);
    exp_t e;
    rst_n         = (rn != 0);
    bus.Start     = (st != 0);
    bus.BranchEn  = (br != 0);
    bus.Taken     = (tk != 0);
    bus.Halt      = (hl != 0);
    bus.TargetIdx = LUT_W'(idx);
    bus.LutWe     = (we != 0);
    bus.LutWaddr  = LUT_W'(wa);
    bus.LutWdata  = PC_W'(wd);
    model_edge(rn, st, br, tk, hl, idx, we, wa, wd);
    e.pc = m_pc; e.running = (m_mode == 1); e.done = (m_mode == 2);
    e.wrap = m_wrap; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();          cyc(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic start();         cyc(1, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic halt();          cyc(1, 0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic branch(input int idx, input int tk); cyc(1, 0, 1, tk, 0, idx, 0, 0, 0); endtask
  task automatic lut_wr(input int a, input int d);    cyc(1, 0, 0, 0, 0, 0, 1, a, d); endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc",      int'(bus.PC),         e.pc);
        check("running", int'(bus.Running),    e.running);
        check("done",    int'(bus.Done),       e.done);
        check("pcwrap",  int'(bus.PcWrap),     e.wrap);
        check("cyclecnt", int'(bus.CycleCount), e.cnt);
      end
    end
  end

  initial begin : driver
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 0, 1, 3, 99);
    check("reset_pc", int'(bus.PC), 0);
    check("reset_running", int'(bus.Running), 0);

    // Straight-line run, halt at PC 5.
    start();
    for (int i = 0; i < 20 && m_pc != 5; i++) idle();
    halt();
    check("t1_done", int'(bus.Done), 1);
    check("t1_pc", int'(bus.PC), 5);
    check("t1_cnt", int'(bus.CycleCount), 6);
    idle();
    check("t1_pc_held", int'(bus.PC), 5);

    // Taken and not-taken branch.
    lut_wr(3, 40);
    lut_wr(4, 2);
    lut_wr(5, 7);
    start();
    idle(); idle();
    branch(3, 1);
    check("t2_taken", int'(bus.PC), 40);
    branch(4, 1);
    check("t2_back", int'(bus.PC), 2);
    branch(3, 0);
    check("t2_not_taken", int'(bus.PC), 3);
    cyc(1, 0, 0, 1, 0, 3, 0, 0, 0);
    check("t2_taken_only", int'(bus.PC), 4);

    // Halt beats a taken branch.
    branch(5, 1);
    cyc(1, 0, 1, 1, 1, 3, 0, 0, 0);
    check("t3_halt_pc", int'(bus.PC), 7);
    check("t3_done", int'(bus.Done), 1);

    // Same-edge LUT write and taken read.
    start();
    cyc(1, 0, 1, 1, 0, 3, 1, 3, 50);
    check("t4_old", int'(bus.PC), 40);
    branch(3, 1);
    check("t4_new", int'(bus.PC), 50);

    // Wrap from 1023 to 0, then restart clears the flag.
    lut_wr(1, 1020);
    branch(1, 1);
    for (int i = 0; i < 3; i++) idle();
    check("t5_pc_max", int'(bus.PC), 1023);
    check("t5_no_wrap_yet", int'(bus.PcWrap), 0);
    idle();
    check("t5_pc_zero", int'(bus.PC), 0);
    check("t5_wrap", int'(bus.PcWrap), 1);
    halt();
    cyc(1, 1, 1, 1, 0, 1, 0, 0, 0);
    check("t5_wrap_clr", int'(bus.PcWrap), 0);
    check("t5_restart_pc", int'(bus.PC), 0);
    check("t5_restart_cnt", int'(bus.CycleCount), 0);

    // Reset mid-run clears LUT.
    for (int i = 0; i < 12; i++) idle();
    check("t6_pc12", int'(bus.PC), 12);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_rst_pc", int'(bus.PC), 0);
    check("t6_rst_running", int'(bus.Running), 0);
    start();
    branch($urandom_range(0, (1 << LUT_W) - 1), 1);
    check("t6_lut_cleared", int'(bus.PC), 0);

    // Counter saturation and hold in DONE.
    start();
    for (int i = 0; i < CNT_MAX + 4; i++) idle();
    check("t7_sat", int'(bus.CycleCount), CNT_MAX);
    halt();
    idle();
    check("t7_sat_done", int'(bus.CycleCount), CNT_MAX);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0) ? 1 : 0,
          ($urandom_range(0, 9) == 0) ? 1 : 0,
          ($urandom_range(0, 2) == 0) ? 1 : 0,
          int'($urandom_range(0, 1)),
          ($urandom_range(0, 29) == 0) ? 1 : 0,
          int'($urandom_range(0, (1 << LUT_W) - 1)),
          ($urandom_range(0, 3) == 0) ? 1 : 0,
          int'($urandom_range(0, (1 << LUT_W) - 1)),
          int'($urandom_range(0, PC_MOD - 1)));
    end

    idle();
    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
